// File: rtl/fanout_1to8_tree.sv
// 1-to-8 routing tree of one-entry registered nodes (root -> 2 -> 4 -> 8 leaves).
// Optional broadcast forking is enabled by defining FANOUT_BROADCAST_EN.
module fanout_1to8_tree #(
  parameter int unsigned DW = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [DW-1:0]   in_data,
  input  logic [2:0]      in_dest,
`ifdef FANOUT_BROADCAST_EN
  input  logic            in_bcast,
`endif
  output logic [7:0]      out_valid,
  input  logic [7:0]      out_ready,
  output logic [8*DW-1:0] out_data
);

  logic          root_full_q, root_full_d;
  logic [DW-1:0] root_data_q;
  logic [2:0]    root_dest_q;
  logic [1:0]    l1_full_q, l1_full_d;
  logic [DW-1:0] l1_data_q [2];
  logic [1:0]    l1_dest_q [2];
  logic [3:0]    l2_full_q, l2_full_d;
  logic [DW-1:0] l2_data_q [4];
  logic [3:0]    l2_dest_q;
  logic [7:0]    leaf_full_q, leaf_full_d;
  logic [DW-1:0] leaf_data_q [8];

  logic          root_bc;
  logic [1:0]    l1_bc;
  logic [3:0]    l2_bc;

  logic          root_leave, root_acc, root_push;
  logic [1:0]    l1_leave, l1_acc, l1_push;
  logic [3:0]    l2_leave, l2_acc, l2_push;
  logic [7:0]    leaf_leave, leaf_acc, leaf_push;

`ifdef FANOUT_BROADCAST_EN
  logic          root_bc_q;
  logic [1:0]    l1_bc_q;
  logic [3:0]    l2_bc_q;

  always_comb begin
    root_bc = root_bc_q;
    l1_bc   = l1_bc_q;
    l2_bc   = l2_bc_q;
  end

  // The broadcast flag travels with the word; it is qualified by the full flags.
  always_ff @(posedge clk) begin
    if (root_push) root_bc_q <= in_bcast;
    for (int unsigned i = 0; i < 2; i++)
      if (l1_push[i]) l1_bc_q[i] <= root_bc_q;
    for (int unsigned j = 0; j < 4; j++)
      if (l2_push[j]) l2_bc_q[j] <= l1_bc_q[j/2];
  end
`else
  always_comb begin
    root_bc = 1'b0;
    l1_bc   = '0;
    l2_bc   = '0;
  end
`endif

  // Acceptance ripples from the leaves up to the root; a broadcast node needs both children.
  always_comb begin
    leaf_leave = leaf_full_q & out_ready;
    leaf_acc   = ~leaf_full_q | leaf_leave;

    l2_leave = '0;
    for (int unsigned j = 0; j < 4; j++) begin
      if (l2_bc[j])
        l2_leave[j] = l2_full_q[j] & leaf_acc[2*j] & leaf_acc[2*j+1];
      else
        l2_leave[j] = l2_full_q[j] & (l2_dest_q[j] ? leaf_acc[2*j+1] : leaf_acc[2*j]);
    end
    l2_acc = ~l2_full_q | l2_leave;

    l1_leave = '0;
    for (int unsigned i = 0; i < 2; i++) begin
      if (l1_bc[i])
        l1_leave[i] = l1_full_q[i] & l2_acc[2*i] & l2_acc[2*i+1];
      else
        l1_leave[i] = l1_full_q[i] & (l1_dest_q[i][1] ? l2_acc[2*i+1] : l2_acc[2*i]);
    end
    l1_acc = ~l1_full_q | l1_leave;

    if (root_bc)
      root_leave = root_full_q & l1_acc[0] & l1_acc[1];
    else
      root_leave = root_full_q & (root_dest_q[2] ? l1_acc[1] : l1_acc[0]);
    root_acc = ~root_full_q | root_leave;
    in_ready = root_acc;
  end

  always_comb begin
    root_push = in_valid & root_acc;
    l1_push   = '0;
    l2_push   = '0;
    leaf_push = '0;
    for (int unsigned i = 0; i < 2; i++)
      l1_push[i] = root_leave & (root_bc | (root_dest_q[2] == i[0]));
    for (int unsigned j = 0; j < 4; j++)
      l2_push[j] = l1_leave[j/2] & (l1_bc[j/2] | (l1_dest_q[j/2][1] == j[0]));
    for (int unsigned k = 0; k < 8; k++)
      leaf_push[k] = l2_leave[k/2] & (l2_bc[k/2] | (l2_dest_q[k/2] == k[0]));

    root_full_d = (root_full_q & ~root_leave) | root_push;
    l1_full_d   = (l1_full_q & ~l1_leave) | l1_push;
    l2_full_d   = (l2_full_q & ~l2_leave) | l2_push;
    leaf_full_d = (leaf_full_q & ~leaf_leave) | leaf_push;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      root_full_q <= 1'b0;
      l1_full_q   <= '0;
      l2_full_q   <= '0;
      leaf_full_q <= '0;
    end else begin
      root_full_q <= root_full_d;
      l1_full_q   <= l1_full_d;
      l2_full_q   <= l2_full_d;
      leaf_full_q <= leaf_full_d;
    end
  end

  // Payload registers carry no reset; only the dest bits still needed downstream are kept.
  always_ff @(posedge clk) begin
    if (root_push) begin
      root_data_q <= in_data;
      root_dest_q <= in_dest;
    end
    for (int unsigned i = 0; i < 2; i++)
      if (l1_push[i]) begin
        l1_data_q[i] <= root_data_q;
        l1_dest_q[i] <= root_dest_q[1:0];
      end
    for (int unsigned j = 0; j < 4; j++)
      if (l2_push[j]) begin
        l2_data_q[j] <= l1_data_q[j/2];
        l2_dest_q[j] <= l1_dest_q[j/2][0];
      end
    for (int unsigned k = 0; k < 8; k++)
      if (leaf_push[k]) leaf_data_q[k] <= l2_data_q[k/2];
  end

  always_comb begin
    out_valid = leaf_full_q;
    out_data  = '0;
    for (int unsigned k = 0; k < 8; k++)
      out_data[k*DW +: DW] = leaf_data_q[k];
  end

endmodule

// File: tb/tb_fanout_1to8_tree.sv
// Directed self-checking bench for fanout_1to8_tree; broadcast cases run when
// FANOUT_BROADCAST_EN is defined.
module tb_fanout_1to8_tree;
  localparam int unsigned DW = 8;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            in_valid;
  logic            in_ready;
  logic [DW-1:0]   in_data;
  logic [2:0]      in_dest;
`ifdef FANOUT_BROADCAST_EN
  logic            in_bcast;
`endif
  logic [7:0]      out_valid;
  logic [7:0]      out_ready;
  logic [8*DW-1:0] out_data;

  always #5 clk = ~clk;

  fanout_1to8_tree #(.DW(DW)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .in_dest  (in_dest),
`ifdef FANOUT_BROADCAST_EN
    .in_bcast (in_bcast),
`endif
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data)
  );

  typedef struct packed {
    logic [7:0] data;
    logic [2:0] dest;
    logic       bcast;
  } tx_t;

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;
  tx_t         tx_q[$];
  logic [7:0]  exp_q[8][$];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_idle();
    in_valid = 1'b0;
    in_data  = '0;
    in_dest  = '0;
`ifdef FANOUT_BROADCAST_EN
    in_bcast = 1'b0;
`endif
  endtask

  task automatic drive_word(input logic [7:0] d, input logic [2:0] dst, input logic bc);
    in_valid = 1'b1;
    in_data  = d;
    in_dest  = dst;
`ifdef FANOUT_BROADCAST_EN
    in_bcast = bc;
`else
    if (bc) $display("broadcast requested without broadcast build");
`endif
  endtask

  // Each cycle: score leaf handshakes, offer the head of tx_q, advance one edge.
  task automatic run(input int unsigned cycles);
    for (int unsigned c = 0; c < cycles; c++) begin
      bit take;
      for (int k = 0; k < 8; k++)
        if (out_valid[k] && out_ready[k]) begin
          if (exp_q[k].size() == 0)
            check($sformatf("leaf%0d_unexpected", k), exp_q[k].size(), 1);
          else
            check($sformatf("leaf%0d_data", k), out_data[k*8 +: 8], exp_q[k].pop_front());
        end
      if (tx_q.size() > 0) drive_word(tx_q[0].data, tx_q[0].dest, tx_q[0].bcast);
      else drive_idle();
      #1;
      take = (tx_q.size() > 0) && in_ready;
      step();
      if (take) void'(tx_q.pop_front());
    end
    drive_idle();
  endtask

  task automatic check_drained(input string tag);
    for (int k = 0; k < 8; k++)
      check($sformatf("%s_leaf%0d_pending", tag, k), exp_q[k].size(), 0);
    check($sformatf("%s_tx_pending", tag), tx_q.size(), 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [7:0] ev;
    rst_n     = 1'b0;
    out_ready = '1;
    drive_idle();
    repeat (3) @(posedge clk);
    #1;
    check("reset_out_valid", out_valid, 8'h00);
    check("reset_in_ready", in_ready, 1);
    rst_n = 1'b1;
    step();
    check("post_reset_out_valid", out_valid, 8'h00);
    check("post_reset_in_ready", in_ready, 1);

    // Single word, minimum latency
    drive_word(8'hA5, 3'd5, 1'b0);
    step();
    drive_idle();
    check("t1_edge0", out_valid, 8'h00);
    step();
    check("t1_edge1", out_valid, 8'h00);
    step();
    check("t1_edge2", out_valid, 8'h00);
    step();
    check("t1_edge3_valid", out_valid, 8'h20);
    check("t1_edge3_data", out_data[47:40], 8'hA5);
    step();
    check("t1_consumed", out_valid, 8'h00);

    // Back-to-back to every leaf
    for (int e = 0; e < 12; e++) begin
      if (e < 8) begin
        drive_word(8'h10 + 8'(e), 3'(e), 1'b0);
        check($sformatf("t2_in_ready_%0d", e), in_ready, 1);
      end else drive_idle();
      step();
      ev = (e >= 3 && e <= 10) ? (8'h01 << (e - 3)) : 8'h00;
      check($sformatf("t2_valid_e%0d", e), out_valid, ev);
      if (e >= 3 && e <= 10)
        check($sformatf("t2_data_e%0d", e), out_data[(e-3)*8 +: 8], 8'h10 + 8'(e - 3));
    end

    // Full path to leaf 3 blocks the root
    out_ready = 8'hF7;
    for (int i = 0; i < 5; i++) begin
      tx_q.push_back('{data: 8'h30 + 8'(i), dest: 3'd3, bcast: 1'b0});
      exp_q[3].push_back(8'h30 + 8'(i));
    end
    run(6);
    check("t3_in_ready_low", in_ready, 0);
    check("t3_fifth_waiting", tx_q.size(), 1);
    check("t3_leaf3_valid", out_valid, 8'h08);
    check("t3_leaf3_head", out_data[31:24], 8'h30);
    run(2);
    check("t3_leaf3_stable", out_data[31:24], 8'h30);
    check("t3_still_blocked", in_ready, 0);
    out_ready = 8'hFF;
    run(12);
    check_drained("t3");

    // Stalled leaf 0 does not delay a word to leaf 7
    out_ready = 8'hFE;
    tx_q.push_back('{data: 8'h40, dest: 3'd0, bcast: 1'b0});
    exp_q[0].push_back(8'h40);
    run(4);
    check("t4_leaf0_held", out_valid, 8'h01);
    drive_word(8'h47, 3'd7, 1'b0);
    step();
    drive_idle();
    step();
    step();
    check("t4_edge2", out_valid, 8'h01);
    step();
    check("t4_edge3_valid", out_valid, 8'h81);
    check("t4_leaf7_data", out_data[63:56], 8'h47);
    check("t4_leaf0_stable", out_data[7:0], 8'h40);
    exp_q[7].push_back(8'h47);
    out_ready = 8'hFF;
    run(2);
    check_drained("t4");

    // Reset with words in flight
    out_ready = 8'h00;
    tx_q.push_back('{data: 8'h51, dest: 3'd1, bcast: 1'b0});
    tx_q.push_back('{data: 8'h52, dest: 3'd2, bcast: 1'b0});
    tx_q.push_back('{data: 8'h56, dest: 3'd6, bcast: 1'b0});
    run(4);
    check("t5_before_reset", out_valid, 8'h02);
    rst_n = 1'b0;
    #1;
    check("t5_async_clear", out_valid, 8'h00);
    check("t5_in_ready_in_reset", in_ready, 1);
    step();
    rst_n = 1'b1;
    out_ready = 8'hFF;
    for (int i = 0; i < 6; i++) begin
      step();
      check($sformatf("t5_no_stale_%0d", i), out_valid, 8'h00);
    end
    drive_word(8'h5A, 3'd2, 1'b0);
    step();
    drive_idle();
    step();
    step();
    check("t5_edge2", out_valid, 8'h00);
    step();
    check("t5_edge3_valid", out_valid, 8'h04);
    check("t5_edge3_data", out_data[23:16], 8'h5A);
    step();
    check("t5_consumed", out_valid, 8'h00);

`ifdef FANOUT_BROADCAST_EN
    // Broadcast reaches all leaves together
    out_ready = 8'hFF;
    tx_q.push_back('{data: 8'h3C, dest: 3'd2, bcast: 1'b1});
    for (int k = 0; k < 8; k++) exp_q[k].push_back(8'h3C);
    run(4);
    check("b1_all_valid", out_valid, 8'hFF);
    check("b1_all_data", out_data, {8{8'h3C}});
    run(1);
    check_drained("b1");

    // Leaf 6 stalls; later broadcasts back up without loss
    out_ready = 8'hBF;
    for (int i = 0; i < 4; i++) begin
      tx_q.push_back('{data: 8'h3D + 8'(i), dest: 3'(i), bcast: 1'b1});
      for (int k = 0; k < 8; k++) exp_q[k].push_back(8'h3D + 8'(i));
    end
    run(12);
    check("b2_leaf6_held", out_valid[6], 1);
    check("b2_leaf6_data", out_data[55:48], 8'h3D);
    check("b2_in_ready_low", in_ready, 0);
    out_ready = 8'hFF;
    run(12);
    check_drained("b2");
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/fanout_1to8_tree.md
FANOUT_1TO8_TREE -- requirements
Module: fanout_1to8_tree

Interface
REQ-001 Parameter DW, default 8: data width, in bits, of each word.
REQ-002 clk  input  1  single clock; all state changes on the rising edge.
REQ-003 rst_n  input  1  asynchronous active-low reset.
REQ-004 in_valid  input  1  source offers a word.
REQ-005 in_ready  output  1  block accepts a word; transfer occurs when in_valid && in_ready at the rising edge.
REQ-006 in_data  input  DW  word payload.
REQ-007 in_dest  input  3  destination leaf index 0..7.
REQ-008 in_bcast  input  1  broadcast request; port exists only when FANOUT_BROADCAST_EN is defined.
REQ-009 out_valid  output  8  leaf k holds a word.
REQ-010 out_ready  input  8  leaf k sink accepts; transfer on out_valid[k] && out_ready[k].
REQ-011 out_data  output  8*DW  leaf k word on bits [k*DW +: DW].

Function
REQ-012 Three-level binary routing tree of one-entry registered nodes: root (1) -> L1 (2, chosen by dest[2]) -> L2 (4, chosen by dest[2:1]) -> leaf registers (8, chosen by dest[2:0]).
REQ-013 Each node holds data, dest and a full flag; the node accepts when empty, or when full and its content leaves in the same cycle.
REQ-014 A full node moves its content to the selected child only when that child accepts in the same cycle; otherwise it holds.
REQ-015 in_ready = !root_full || root_leaving, combinational from node state and child acceptance; it is never combinational from in_valid.
REQ-016 Latency: a word accepted at edge N sets out_valid[dest] at edge N+3 when the path is empty; 3 cycles is the minimum.
REQ-017 Throughput: one word per cycle sustained with all out_ready high, for any dest sequence.
REQ-018 Ordering: words to the same leaf emerge in acceptance order; no word is dropped, duplicated or misrouted.
REQ-019 Backpressure: out_ready[k] low stalls only the nodes on the path to leaf k whose content targets that path; other paths keep flowing.
REQ-020 Leaf k remains valid with stable out_data until accepted.
REQ-021 With all nodes full on one path, the path holds 4 words; the next in_valid sees in_ready low until space frees.
REQ-022 out_data for an empty leaf holds its last value; the value is don't-care for checkers.

Reset
REQ-023 rst_n low asynchronously clears every full flag; out_valid = 0 and in_ready = 1 after reset is released.
REQ-024 Data and dest registers are not reset.
REQ-025 Words in flight when reset is asserted are discarded; after release, the first accepted word sees the 3-cycle minimum latency.

Configuration
REQ-026 Macro FANOUT_BROADCAST_EN: when defined, in_bcast is present and the node's bcast flag travels with the word.
REQ-027 A bcast word forks at each node: it moves only when both children accept in the same cycle, and each child receives a copy with bcast set; in_dest is ignored.
REQ-028 A bcast word reaches all 8 leaves in the same cycle at N+3 when the tree is idle.
REQ-029 Without the macro, there is no in_bcast port and no bcast logic, and behaviour is as REQ-012..REQ-022.

Verification
REQ-030 Reset, then a single word 0xA5 to dest 5 at cycle 0 with all out_ready high: out_valid = 8'b0010_0000 at cycle 3 with out_data[47:40] = 0xA5, then out_valid = 0.
REQ-031 Eight back-to-back words with dest 0..7 and data 0x10..0x17, all out_ready high: in_ready stays 1; each leaf k shows 0x10+k exactly once, at cycle k+3.
REQ-032 out_ready[3] = 0 with five words to dest 3: the first four are accepted, in_ready drops before the fifth, and a word to dest 4 still arriving at leaf 4 is not expected because the root is blocked; release ready and confirm all five arrive in order.
REQ-033 out_ready[0] low with one word to dest 0 held, then a word to dest 7: the dest-7 word delivers at minimum latency while leaf 0 stays valid and stable.
REQ-034 rst_n pulsed low for one cycle while three words are in flight: all out_valid clear immediately and no stale word appears afterwards.
REQ-035 (FANOUT_BROADCAST_EN) A bcast word 0x3C with out_ready = 8'hFF: all out_valid bits are set together at cycle 3 with 0x3C on every leaf; repeat with out_ready[6] = 0 and check that leaf 6 holds and later bcast words stall without loss.
